// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and text helpers for the HD44780 character-LCD driver.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  localparam logic [15:0] CHOICE_BOTH  = 16'h0000;
  localparam logic [15:0] CHOICE_ONE   = 16'h0001;
  localparam logic [15:0] CHOICE_BLANK = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_IDLE, ST_L1_ADDR, ST_L1_CHARS, ST_L2_ADDR, ST_L2_CHARS
  } lcd_state_e;

  typedef enum logic [1:0] {BW_IDLE, BW_SETUP, BW_PULSE, BW_WAIT} bw_phase_e;

  typedef struct packed {
    logic [15:0] choice;
    logic [15:0] val1;
    logic [15:0] val2;
  } snap_t;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: init_cmd = FUNC_SET;
      4'd2:       init_cmd = DISP_ON;
      4'd3:       init_cmd = CLEAR;
      default:    init_cmd = ENTRY;
    endcase
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    digit_char = (d <= 4'd9) ? ZERO + {4'h0, d} : QMARK;
  endfunction

  // "VALn: dddd" followed by spaces.
  function automatic logic [7:0] val_char(input logic line2, input logic [3:0] col,
                                          input logic [15:0] digits);
    case (col)
      4'd0:    val_char = 8'h56;
      4'd1:    val_char = 8'h41;
      4'd2:    val_char = 8'h4C;
      4'd3:    val_char = line2 ? 8'h32 : 8'h31;
      4'd4:    val_char = 8'h3A;
      4'd6:    val_char = digit_char(digits[15:12]);
      4'd7:    val_char = digit_char(digits[11:8]);
      4'd8:    val_char = digit_char(digits[7:4]);
      4'd9:    val_char = digit_char(digits[3:0]);
      default: val_char = SPACE;
    endcase
  endfunction

  // "MODE ????" followed by spaces.
  function automatic logic [7:0] mode_char(input logic [3:0] col);
    case (col)
      4'd0:                   mode_char = 8'h4D;
      4'd1:                   mode_char = 8'h4F;
      4'd2:                   mode_char = 8'h44;
      4'd3:                   mode_char = 8'h45;
      4'd5, 4'd6, 4'd7, 4'd8: mode_char = QMARK;
      default:                mode_char = SPACE;
    endcase
  endfunction

  function automatic logic [7:0] line_char(input snap_t s, input logic line2,
                                           input logic [3:0] col);
    if (s.choice == CHOICE_BLANK)     line_char = SPACE;
    else if (s.choice == CHOICE_BOTH) line_char = val_char(line2, col, line2 ? s.val2 : s.val1);
    else if (s.choice == CHOICE_ONE)  line_char = line2 ? SPACE : val_char(1'b0, col, s.val1);
    else                              line_char = line2 ? SPACE : mode_char(col);
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one HD44780 write cycle: setup with en low, enable pulse, then the settle wait.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned EN_PULSE   = 25,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLEAR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wr_byte,
  input  logic       wr_rs,
  input  logic       long_wait,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       done,
  output logic [1:0] phase_dbg
);

  // Handshake: start is only honoured while idle or in the done cycle; done is a one-cycle
  // pulse on the last wait cycle, so a start in that same cycle chains bytes with no bubble.
  bw_phase_e   phase_q, phase_d;
  logic [31:0] cnt_q;
  logic [7:0]  data_q;
  logic        rs_q, long_q;
  logic [31:0] wait_last;
  logic        accept;

  assign wait_last = long_q ? 32'(CLEAR_WAIT - 1) : 32'(CMD_WAIT - 1);
  assign accept    = start && ((phase_q == BW_IDLE) || done);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= BW_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= (phase_d != phase_q || phase_q == BW_IDLE) ? 32'd0 : cnt_q + 32'd1;
      if (accept) begin
        data_q <= wr_byte;
        rs_q   <= wr_rs;
        long_q <= long_wait;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      BW_IDLE:  if (start) phase_d = BW_SETUP;
      BW_SETUP: if (cnt_q == 32'(SETUP_CYC - 1)) phase_d = BW_PULSE;
      BW_PULSE: if (cnt_q == 32'(EN_PULSE - 1)) phase_d = BW_WAIT;
      BW_WAIT:  if (done) phase_d = start ? BW_SETUP : BW_IDLE;
      default:  phase_d = BW_IDLE;
    endcase
  end

  always_comb begin
    done      = (phase_q == BW_WAIT) && (cnt_q == wait_last);
    lcd_en    = (phase_q == BW_PULSE);
    lcd_data  = data_q;
    lcd_rs    = rs_q;
    phase_dbg = phase_q;
  end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// 16x2 HD44780 engine: power-up init, then redraws both lines whenever the inputs change.
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_WAIT = 750000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_PULSE     = 25,
  parameter int unsigned CMD_WAIT     = 2000,
  parameter int unsigned CLEAR_WAIT   = 82000
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic [15:0] choice,
  input  logic [3:0]  thousands_1, hundreds_1, tens_1, ones_1,
  input  logic [3:0]  thousands_2, hundreds_2, tens_2, ones_2,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  state_dbg,
  output logic [1:0]  phase_dbg
);

  lcd_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] pw_cnt_q;
  snap_t       snap_q, snap_in;
  logic        snap_valid_q, changed, latch;
  logic        fd_q, fd_d;
  logic        start, wr_rs, long_wait, wr_done;
  logic [7:0]  wr_byte;

  assign snap_in = '{choice: choice,
                     val1: {thousands_1, hundreds_1, tens_1, ones_1},
                     val2: {thousands_2, hundreds_2, tens_2, ones_2}};
  assign changed = !snap_valid_q || (snap_in != snap_q);

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q      <= ST_POWERUP;
      idx_q        <= '0;
      pw_cnt_q     <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      fd_q         <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fd_q     <= fd_d;
      pw_cnt_q <= (state_q == ST_POWERUP) ? pw_cnt_q + 32'd1 : 32'd0;
      if (latch) begin
        snap_q       <= snap_in;
        snap_valid_q <= 1'b1;
      end
    end
  end

  // The byte for the writer is chosen from the *next* position so that it is loaded on the
  // same edge the previous byte finishes, giving back-to-back bytes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start   = 1'b0;
    latch   = 1'b0;
    fd_d    = 1'b0;
    case (state_q)
      ST_POWERUP: if (pw_cnt_q == 32'(POWERUP_WAIT - 1)) begin
        state_d = ST_INIT; idx_d = 4'd0; start = 1'b1;
      end
      ST_INIT: if (wr_done) begin
        if (idx_q == 4'd4) begin state_d = ST_IDLE; idx_d = 4'd0; end
        else begin idx_d = idx_q + 4'd1; start = 1'b1; end
      end
      ST_IDLE: if (changed) begin
        state_d = ST_L1_ADDR; latch = 1'b1; start = 1'b1;
      end
      ST_L1_ADDR: if (wr_done) begin state_d = ST_L1_CHARS; idx_d = 4'd0; start = 1'b1; end
      ST_L1_CHARS: if (wr_done) begin
        start = 1'b1;
        if (idx_q == 4'd15) begin state_d = ST_L2_ADDR; idx_d = 4'd0; end
        else idx_d = idx_q + 4'd1;
      end
      ST_L2_ADDR: if (wr_done) begin state_d = ST_L2_CHARS; idx_d = 4'd0; start = 1'b1; end
      ST_L2_CHARS: if (wr_done) begin
        if (idx_q == 4'd15) begin state_d = ST_IDLE; idx_d = 4'd0; fd_d = 1'b1; end
        else begin idx_d = idx_q + 4'd1; start = 1'b1; end
      end
      default: state_d = ST_POWERUP;
    endcase

    wr_byte   = 8'h00;
    wr_rs     = 1'b0;
    long_wait = (state_d == ST_INIT) && (idx_d == 4'd3);
    case (state_d)
      ST_INIT:     wr_byte = init_cmd(idx_d);
      ST_L1_ADDR:  wr_byte = LINE1;
      ST_L2_ADDR:  wr_byte = LINE2;
      ST_L1_CHARS: begin wr_byte = line_char(snap_q, 1'b0, idx_d); wr_rs = 1'b1; end
      ST_L2_CHARS: begin wr_byte = line_char(snap_q, 1'b1, idx_d); wr_rs = 1'b1; end
      default:     wr_byte = 8'h00;
    endcase
  end

  always_comb begin
    lcd_on     = 1'b1;
    lcd_blon   = 1'b1;
    lcd_rw     = 1'b0;
    busy       = (state_q != ST_IDLE);
    frame_done = fd_q;
    state_dbg  = state_q;
  end

  lcd_byte_writer #(
    .SETUP_CYC(SETUP_CYC), .EN_PULSE(EN_PULSE), .CMD_WAIT(CMD_WAIT), .CLEAR_WAIT(CLEAR_WAIT)
  ) u_writer (
    .clk(clock_50), .reset(reset), .start(start), .wr_byte(wr_byte), .wr_rs(wr_rs),
    .long_wait(long_wait), .lcd_en(lcd_en), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .done(wr_done), .phase_dbg(phase_dbg)
  );

endmodule
